// File: rtl/register_file_unit_if.sv
// Register file access bundle: two read ports and one write port.
// Ports (master = decode/writeback side, slave = register file):
//   r1, r2     read addresses            (master -> slave)
//   rd         write address             (master -> slave)
//   datawrite  write data                (master -> slave)
//   ru_wr      write enable, active high (master -> slave)
//   r1out      read data for r1          (slave -> master)
//   r2out      read data for r2          (slave -> master)
interface register_file_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] r1;
   logic [ADDR_W-1:0] r2;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] datawrite;
   logic              ru_wr;
   logic [DATA_W-1:0] r1out;
   logic [DATA_W-1:0] r2out;

   modport master (
      output r1, r2, rd, datawrite, ru_wr,
      input  r1out, r2out
   );

   modport slave (
      input  r1, r2, rd, datawrite, ru_wr,
      output r1out, r2out
   );
endinterface

// File: rtl/register_file_unit.sv
// 32 x 32 general-purpose register file, x0 hardwired to zero.
// Ports:
//   clk    system clock, writes on the rising edge
//   rst_n  asynchronous active-low reset, clears all registers
//   bus    register_file_unit_if slave: r1/r2 combinational reads,
//          rd/datawrite/ru_wr synchronous write
// BYPASS=1 forwards datawrite to a read port addressing the register
// being written in the same cycle.
module register_file_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter bit          BYPASS = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   register_file_unit_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] reg_q [DEPTH];
   logic [DATA_W-1:0] reg_d [DEPTH];
   logic [DATA_W-1:0] r1_val;
   logic [DATA_W-1:0] r2_val;

   // Next-state: single write port, x0 never written
   always_comb begin
      reg_d = reg_q;
      if (bus.ru_wr && (bus.rd != '0)) begin
         reg_d[bus.rd] = bus.datawrite;
      end
      reg_d[0] = '0;
   end

   // Storage, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q <= '{default: '0};
      end else begin
         reg_q <= reg_d;
      end
   end

   // Combinational read ports; bypass is suppressed while reset is held
   always_comb begin
      r1_val = '0;
      r2_val = '0;
      if (bus.r1 != '0) begin
         r1_val = reg_q[bus.r1];
         if (BYPASS && rst_n && bus.ru_wr && (bus.rd == bus.r1)) begin
            r1_val = bus.datawrite;
         end
      end
      if (bus.r2 != '0) begin
         r2_val = reg_q[bus.r2];
         if (BYPASS && rst_n && bus.ru_wr && (bus.rd == bus.r2)) begin
            r2_val = bus.datawrite;
         end
      end
   end

   assign bus.r1out = r1_val;
   assign bus.r2out = r2_val;

endmodule

// File: tb/tb_register_file_unit.sv
// Bench for register_file_unit: one instance per BYPASS setting, driven
// identically and compared against an array model of the register file.
module tb_register_file_unit;
   logic clk;
   logic rst_n;

   register_file_unit_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
   register_file_unit_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

   register_file_unit #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );
   register_file_unit #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [32];
   logic [4:0]  s_r1, s_r2, s_rd;
   logic [31:0] s_dw;
   logic        s_wr;

   task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] ad, input logic [31:0] dw,
                        input logic we);
      s_r1 = a1; s_r2 = a2; s_rd = ad; s_dw = dw; s_wr = we;
      bus0.r1 = a1; bus0.r2 = a2; bus0.rd = ad; bus0.datawrite = dw; bus0.ru_wr = we;
      bus1.r1 = a1; bus1.r2 = a2; bus1.rd = ad; bus1.datawrite = dw; bus1.ru_wr = we;
   endtask

   // Expected read value from the architectural rules
   function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 32'd0;
      if (byp && s_wr && s_rd == a) return s_dw;
      return model[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      #1;
      chk({tag, "/b0_r1"}, bus0.r1out, exp_rd(1'b0, s_r1));
      chk({tag, "/b0_r2"}, bus0.r2out, exp_rd(1'b0, s_r2));
      chk({tag, "/b1_r1"}, bus1.r1out, exp_rd(1'b1, s_r1));
      chk({tag, "/b1_r2"}, bus1.r2out, exp_rd(1'b1, s_r2));
   endtask

   // One rising edge; the model commits the write the same way the spec says
   task automatic tick();
      @(posedge clk);
      if (rst_n && s_wr && s_rd != 5'd0) model[s_rd] = s_dw;
      #1;
   endtask

   initial begin
      logic [31:0] x0_vals [4];
      x0_vals[0] = 32'd481184; x0_vals[1] = 32'd572264;
      x0_vals[2] = 32'd342916; x0_vals[3] = 32'd1234673;
      foreach (model[i]) model[i] = 32'd0;

      rst_n = 1'b0;
      drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
      #3;
      check_all("reset_hold");
      // write attempted under reset is dropped
      drive(5'd4, 5'd4, 5'd4, 32'hDEAD_BEEF, 1'b1);
      tick();
      check_all("reset_write_drop");
      rst_n = 1'b1;
      drive(5'd4, 5'd4, 5'd4, 32'd0, 1'b0);
      check_all("after_release");

      // x0 immutability
      for (int i = 0; i < 4; i++) begin
         drive(5'd1, 5'd0, 5'd0, x0_vals[i], 1'b1);
         check_all("x0_pre");
         tick();
         check_all("x0_post");
      end

      // basic write/read
      drive(5'd1, 5'd2, 5'd1, 32'd481184, 1'b1);
      tick();
      drive(5'd1, 5'd2, 5'd2, 32'd572264, 1'b1);
      check_all("basic_x1");
      tick();
      drive(5'd1, 5'd2, 5'd2, 32'd572264, 1'b0);
      check_all("basic_x2");
      chk("basic_abs_r1", bus0.r1out, 32'd481184);
      chk("basic_abs_r2", bus0.r2out, 32'd572264);

      // write disable
      drive(5'd1, 5'd2, 5'd1, 32'd342916, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("wr_disable");
      end
      chk("wr_disable_abs", bus1.r1out, 32'd481184);

      // same-cycle read/write of x3
      drive(5'd3, 5'd3, 5'd3, 32'd1234673, 1'b0);
      check_all("rdw_idle");
      drive(5'd3, 5'd3, 5'd3, 32'd1234673, 1'b1);
      check_all("rdw_pre");
      chk("rdw_b0_old", bus0.r1out, 32'd0);
      chk("rdw_b1_fwd", bus1.r1out, 32'd1234673);
      tick();
      drive(5'd3, 5'd3, 5'd3, 32'd1234673, 1'b0);
      check_all("rdw_post");
      chk("rdw_b0_new", bus0.r1out, 32'd1234673);

      // sweep all registers
      for (int i = 1; i < 32; i++) begin
         drive(5'(i), 5'(i), 5'(i), 32'(1000 + i), 1'b1);
         tick();
         drive(5'(i), 5'(i), 5'(i), 32'(1000 + i), 1'b0);
         check_all("sweep");
         chk("sweep_abs", bus0.r2out, 32'(1000 + i));
      end
      drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
      check_all("sweep_x0");
      drive(5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 1'b1);
      tick();
      drive(5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 1'b0);
      check_all("x31_ones");
      chk("x31_abs", bus1.r1out, 32'hFFFF_FFFF);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
         check_all("rand_pre");
         tick();
         check_all("rand_post");
      end

      // mid-simulation asynchronous reset
      drive(5'd5, 5'd5, 5'd5, 32'd481184, 1'b1);
      tick();
      drive(5'd5, 5'd5, 5'd5, 32'd481184, 1'b0);
      check_all("x5_written");
      chk("x5_abs", bus0.r1out, 32'd481184);
      #1;
      rst_n = 1'b0;
      foreach (model[i]) model[i] = 32'd0;
      #1;
      chk("async_rst_b0_r1", bus0.r1out, 32'd0);
      chk("async_rst_b0_r2", bus0.r2out, 32'd0);
      chk("async_rst_b1_r1", bus1.r1out, 32'd0);
      drive(5'd5, 5'd5, 5'd5, 32'h1234_5678, 1'b1);
      check_all("rst_bypass_gate");
      tick();
      drive(5'd5, 5'd5, 5'd5, 32'd0, 1'b0);
      rst_n = 1'b1;
      check_all("x5_after_release");
      chk("x5_zero_abs", bus0.r2out, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
